// File: rtl/mips.sv
// mips: single-cycle MIPS-32 subset core with a minimal CP0 serving one external interrupt.
// Every instruction retires in one clock; trace ports expose each GPR write and store.
module mips #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] INT_ADDR   = 32'h0000_7F20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        interrupt,
   output logic [31:0] macroscopic_pc,
   output logic [31:0] i_inst_addr,
   input  logic [31:0] i_inst_rdata,
   output logic [31:0] m_data_addr,
   input  logic [31:0] m_data_rdata,
   output logic [31:0] m_data_wdata,
   output logic [3:0]  m_data_byteen,
   output logic [31:0] m_int_addr,
   output logic [3:0]  m_int_byteen,
   output logic [31:0] m_inst_addr,
   output logic        w_grf_we,
   output logic [4:0]  w_grf_addr,
   output logic [31:0] w_grf_wdata,
   output logic [31:0] w_inst_addr
);
   localparam int unsigned NREG = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09, OP_ANDI = 6'h0c, OP_ORI  = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f, OP_COP0 = 6'h10, OP_LB   = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21, OP_LW   = 6'h23, OP_SB   = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29, OP_SW   = 6'h2b;
   localparam logic [5:0] FN_SLL   = 6'h00, FN_JR   = 6'h08, FN_JALR = 6'h09;
   localparam logic [5:0] FN_ERET  = 6'h18, FN_ADD  = 6'h20, FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25, FN_SLT  = 6'h2a, FN_SLTU = 6'h2b;
   localparam logic [4:0] CP_MF    = 5'd0,  CP_MT   = 5'd4;
   localparam logic [4:0] CP0_SR   = 5'd12, CP0_CAUSE = 5'd13, CP0_EPC = 5'd14;
   localparam logic [31:0] SR_MASK = 32'h0000_FC03;

   logic [31:0] pc, sr, epc;
   logic [31:0] gpr [NREG];

   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd, sa;
   logic [31:0] rs_val, rt_val, imm_s, imm_z, pc_plus4, mem_addr, cause, cp0_rdata;
   logic [15:0] load_half;
   logic [7:0]  load_byte;
   logic        take_int, kill, int_hit;

   logic [31:0] next_pc, wr_data, store_data;
   logic [4:0]  wr_addr;
   logic [3:0]  store_be;
   logic        wr_en, is_mtc0, is_eret;

   assign op       = i_inst_rdata[31:26];
   assign rs       = i_inst_rdata[25:21];
   assign rt       = i_inst_rdata[20:16];
   assign rd       = i_inst_rdata[15:11];
   assign sa       = i_inst_rdata[10:6];
   assign fn       = i_inst_rdata[5:0];
   assign imm_s    = {{16{i_inst_rdata[15]}}, i_inst_rdata[15:0]};
   assign imm_z    = {16'h0000, i_inst_rdata[15:0]};
   assign rs_val   = (rs == 5'd0) ? 32'h0 : gpr[rs];
   assign rt_val   = (rt == 5'd0) ? 32'h0 : gpr[rt];
   assign pc_plus4 = pc + 32'd4;
   assign mem_addr = rs_val + imm_s;

   // Cause only mirrors the live request line; nothing in it is stored.
   assign cause    = {16'h0000, 3'b000, interrupt, 12'h000};
   assign take_int = interrupt & sr[12] & sr[0] & ~sr[1];
   assign kill     = reset | take_int;
   assign int_hit  = (mem_addr[31:2] == INT_ADDR[31:2]);

   assign load_half = mem_addr[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];

   always_comb begin
      case (mem_addr[1:0])
         2'd1:    load_byte = m_data_rdata[15:8];
         2'd2:    load_byte = m_data_rdata[23:16];
         2'd3:    load_byte = m_data_rdata[31:24];
         default: load_byte = m_data_rdata[7:0];
      endcase
   end

   always_comb begin
      case (rd)
         CP0_SR:    cp0_rdata = sr;
         CP0_CAUSE: cp0_rdata = cause;
         CP0_EPC:   cp0_rdata = epc;
         default:   cp0_rdata = 32'h0;
      endcase
   end

   // Decode and execute; unlisted encodings fall through as NOPs.
   always_comb begin
      next_pc    = pc_plus4;
      wr_en      = 1'b0;
      wr_addr    = rt;
      wr_data    = 32'h0;
      store_be   = 4'b0000;
      store_data = rt_val;
      is_mtc0    = 1'b0;
      is_eret    = 1'b0;
      case (op)
         OP_RTYPE: begin
            wr_addr = rd;
            case (fn)
               FN_ADD, FN_ADDU: begin wr_en = 1'b1; wr_data = rs_val + rt_val; end
               FN_SUB, FN_SUBU: begin wr_en = 1'b1; wr_data = rs_val - rt_val; end
               FN_AND:  begin wr_en = 1'b1; wr_data = rs_val & rt_val; end
               FN_OR:   begin wr_en = 1'b1; wr_data = rs_val | rt_val; end
               FN_SLT:  begin wr_en = 1'b1; wr_data = 32'($signed(rs_val) < $signed(rt_val)); end
               FN_SLTU: begin wr_en = 1'b1; wr_data = 32'(rs_val < rt_val); end
               FN_SLL:  begin wr_en = 1'b1; wr_data = rt_val << sa; end
               FN_JR:   next_pc = rs_val;
               FN_JALR: begin next_pc = rs_val; wr_en = 1'b1; wr_data = pc_plus4; end
               default: ;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin wr_en = 1'b1; wr_data = rs_val + imm_s; end
         OP_ANDI: begin wr_en = 1'b1; wr_data = rs_val & imm_z; end
         OP_ORI:  begin wr_en = 1'b1; wr_data = rs_val | imm_z; end
         OP_LUI:  begin wr_en = 1'b1; wr_data = {i_inst_rdata[15:0], 16'h0000}; end
         OP_BEQ:  if (rs_val == rt_val) next_pc = pc_plus4 + (imm_s << 2);
         OP_BNE:  if (rs_val != rt_val) next_pc = pc_plus4 + (imm_s << 2);
         OP_J:    next_pc = {pc_plus4[31:28], i_inst_rdata[25:0], 2'b00};
         OP_JAL: begin
            next_pc = {pc_plus4[31:28], i_inst_rdata[25:0], 2'b00};
            wr_en   = 1'b1;
            wr_addr = 5'd31;
            wr_data = pc_plus4;
         end
         OP_LW: begin wr_en = 1'b1; wr_data = m_data_rdata; end
         OP_LH: begin wr_en = 1'b1; wr_data = {{16{load_half[15]}}, load_half}; end
         OP_LB: begin wr_en = 1'b1; wr_data = {{24{load_byte[7]}}, load_byte}; end
         OP_SW: store_be = 4'b1111;
         OP_SH: begin
            store_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
            store_data = {2{rt_val[15:0]}};
         end
         OP_SB: begin
            store_be   = 4'b0001 << mem_addr[1:0];
            store_data = {4{rt_val[7:0]}};
         end
         OP_COP0: begin
            if (rs == CP_MF) begin
               wr_en   = 1'b1;
               wr_data = cp0_rdata;
            end else if (rs == CP_MT) begin
               is_mtc0 = 1'b1;
            end else if (rs[4] && fn == FN_ERET) begin
               is_eret = 1'b1;
               next_pc = epc;
            end
         end
         default: ;
      endcase
   end

   assign macroscopic_pc = pc;
   assign i_inst_addr    = pc;
   assign m_inst_addr    = pc;
   assign w_inst_addr    = pc;
   assign m_data_addr    = mem_addr;
   assign m_int_addr     = mem_addr;
   assign m_data_wdata   = store_data;
   assign m_data_byteen  = (kill | int_hit) ? 4'b0000 : store_be;
   assign m_int_byteen   = (~kill & int_hit) ? store_be : 4'b0000;
   assign w_grf_we       = wr_en & ~kill;
   assign w_grf_addr     = wr_addr;
   assign w_grf_wdata    = wr_data;

   // Architectural state: reset beats interrupt entry, which beats the instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc  <= RESET_PC;
         sr  <= 32'h0;
         epc <= 32'h0;
         for (int i = 0; i < NREG; i++) gpr[5'(i)] <= 32'h0;
      end else if (take_int) begin
         pc    <= HANDLER_PC;
         epc   <= pc;
         sr[1] <= 1'b1;
      end else begin
         pc <= next_pc;
         if (wr_en && wr_addr != 5'd0) gpr[wr_addr] <= wr_data;
         if (is_mtc0 && rd == CP0_SR)  sr  <= rt_val & SR_MASK;
         if (is_mtc0 && rd == CP0_EPC) epc <= rt_val;
         if (is_eret) sr[1] <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mips.sv
// tb_mips: directed and randomized programs for mips, checked cycle by cycle
// against an instruction-level reference model of the ISA subset.
`timescale 1ns/1ps
module tb_mips;
   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
   localparam logic [31:0] INT_ADDR   = 32'h0000_7F20;

   logic        clk = 1'b0;
   logic        reset, interrupt;
   logic [31:0] macroscopic_pc, i_inst_addr, i_inst_rdata, m_data_addr, m_data_rdata;
   logic [31:0] m_data_wdata, m_int_addr, m_inst_addr, w_grf_wdata, w_inst_addr;
   logic [3:0]  m_data_byteen, m_int_byteen;
   logic        w_grf_we;
   logic [4:0]  w_grf_addr;

   logic [31:0] imem [2048];
   logic [31:0] dmem [1024];
   logic        pk_en;
   logic [9:0]  pk_idx;
   logic [31:0] pk_val;

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [31:0] mpc, msr, mepc;
   logic [31:0] mr   [32];
   logic [31:0] mmem [1024];

   // DUT outputs seen during the most recent step
   logic        last_we;
   logic [4:0]  last_waddr;
   logic [31:0] last_wdata, last_mwdata;
   logic [3:0]  last_dbe, last_ibe;

   mips dut (
      .clk(clk), .reset(reset), .interrupt(interrupt),
      .macroscopic_pc(macroscopic_pc), .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
      .m_data_addr(m_data_addr), .m_data_rdata(m_data_rdata), .m_data_wdata(m_data_wdata),
      .m_data_byteen(m_data_byteen), .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
      .m_inst_addr(m_inst_addr), .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr),
      .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr)
   );

   always #5 clk = ~clk;

   assign i_inst_rdata = imem[i_inst_addr[12:2]];
   assign m_data_rdata = dmem[m_data_addr[11:2]];

   always @(posedge clk) begin
      if (pk_en) dmem[pk_idx] <= pk_val;
      for (int i = 0; i < 4; i++)
         if (m_data_byteen[i]) dmem[m_data_addr[11:2]][8*i +: 8] <= m_data_wdata[8*i +: 8];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sa, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [31:0] target);
      return {op, target[27:2]};
   endfunction

   task automatic put(input logic [31:0] addr, input logic [31:0] ins);
      imem[addr[12:2]] = ins;
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 2048; i++) imem[i] = 32'h0;
   endtask

   task automatic poke(input int idx, input logic [31:0] v);
      pk_en  = 1'b1;
      pk_idx = 10'(idx);
      pk_val = v;
      mmem[idx] = v;
      @(posedge clk);
      @(negedge clk);
      pk_en = 1'b0;
   endtask

   // Holds reset across one edge: checks the write/store gating before the edge and the PC after.
   task automatic do_reset(input logic irq);
      reset     = 1'b1;
      interrupt = irq;
      #1;
      chk("rst_we",  32'(w_grf_we),      32'h0);
      chk("rst_dbe", 32'(m_data_byteen), 32'h0);
      chk("rst_ibe", 32'(m_int_byteen),  32'h0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_pc", macroscopic_pc, RESET_PC);
      mpc  = RESET_PC;
      msr  = 32'h0;
      mepc = 32'h0;
      for (int i = 0; i < 32; i++) mr[i] = 32'h0;
      interrupt = 1'b0;
   endtask

   // One instruction: predict from the ISA rules, compare the DUT, then commit the model.
   task automatic step(input logic irq);
      logic [31:0] ins, a, b, se, addr, res, npc, pc4, rdw, sdata;
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd, sa, wa;
      logic [3:0]  be;
      logic [7:0]  bytev;
      logic [15:0] halfv;
      logic        wr, ld, eret, mtc, take, hit;
      interrupt = irq;
      #1;
      ins = imem[mpc[12:2]];
      {op, rs, rt, rd, sa, fn} = ins;
      a     = mr[rs];
      b     = mr[rt];
      se    = 32'($signed(ins[15:0]));
      addr  = a + se;
      pc4   = mpc + 32'd4;
      npc   = pc4;
      rdw   = mmem[addr[11:2]];
      bytev = 8'(rdw >> (8 * addr[1:0]));
      halfv = 16'(rdw >> (16 * addr[1]));
      wr = 1'b0; wa = rt; res = 32'h0; be = 4'h0; sdata = 32'h0;
      ld = 1'b0; eret = 1'b0; mtc = 1'b0;
      case (op)
         6'h00: begin
            wa = rd;
            case (fn)
               6'h20, 6'h21: begin wr = 1'b1; res = a + b; end
               6'h22, 6'h23: begin wr = 1'b1; res = a - b; end
               6'h24: begin wr = 1'b1; res = a & b; end
               6'h25: begin wr = 1'b1; res = a | b; end
               6'h2a: begin wr = 1'b1; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
               6'h2b: begin wr = 1'b1; res = (a < b) ? 32'd1 : 32'd0; end
               6'h00: begin wr = 1'b1; res = b << sa; end
               6'h08: npc = a;
               6'h09: begin npc = a; wr = 1'b1; res = pc4; end
               default: ;
            endcase
         end
         6'h08, 6'h09: begin wr = 1'b1; res = a + se; end
         6'h0c: begin wr = 1'b1; res = a & {16'h0, ins[15:0]}; end
         6'h0d: begin wr = 1'b1; res = a | {16'h0, ins[15:0]}; end
         6'h0f: begin wr = 1'b1; res = {ins[15:0], 16'h0}; end
         6'h04: if (a == b) npc = pc4 + 32'(se * 4);
         6'h05: if (a != b) npc = pc4 + 32'(se * 4);
         6'h02: npc = {pc4[31:28], ins[25:0], 2'b00};
         6'h03: begin npc = {pc4[31:28], ins[25:0], 2'b00}; wr = 1'b1; wa = 5'd31; res = pc4; end
         6'h23: begin wr = 1'b1; ld = 1'b1; res = rdw; end
         6'h21: begin wr = 1'b1; ld = 1'b1; res = 32'($signed(halfv)); end
         6'h20: begin wr = 1'b1; ld = 1'b1; res = 32'($signed(bytev)); end
         6'h2b: begin be = 4'b1111; sdata = b; end
         6'h29: begin be = addr[1] ? 4'b1100 : 4'b0011; sdata = {b[15:0], b[15:0]}; end
         6'h28: begin be = 4'(1 << addr[1:0]); sdata = {b[7:0], b[7:0], b[7:0], b[7:0]}; end
         6'h10: begin
            if (rs == 5'd0) begin
               wr = 1'b1;
               if (rd == 5'd12)      res = msr;
               else if (rd == 5'd13) res = irq ? 32'h0000_1000 : 32'h0;
               else if (rd == 5'd14) res = mepc;
               else                  res = 32'h0;
            end else if (rs == 5'd4) mtc = 1'b1;
            else if (ins == 32'h4200_0018) begin eret = 1'b1; npc = mepc; end
         end
         default: ;
      endcase
      take = irq && msr[12] && msr[0] && !msr[1];
      if (take) begin
         wr = 1'b0; be = 4'h0; mtc = 1'b0; eret = 1'b0; npc = HANDLER_PC;
      end
      hit = (be != 4'h0) && (addr[31:2] == INT_ADDR[31:2]);

      chk("pc",    macroscopic_pc, mpc);
      chk("fetch", i_inst_addr,    mpc);
      chk("we",    32'(w_grf_we),  32'(wr));
      if (wr) begin
         chk("waddr", 32'(w_grf_addr), 32'(wa));
         chk("wdata", w_grf_wdata,     res);
         chk("winst", w_inst_addr,     mpc);
      end
      chk("dbe", 32'(m_data_byteen), 32'(hit ? 4'h0 : be));
      chk("ibe", 32'(m_int_byteen),  32'(hit ? be : 4'h0));
      if (be != 4'h0) begin
         chk("saddr",  m_data_addr,  addr);
         chk("sdata",  m_data_wdata, sdata);
         chk("iaddr",  m_int_addr,   addr);
         chk("sinst",  m_inst_addr,  mpc);
      end
      if (ld && !take) chk("laddr", m_data_addr, addr);
      last_we = w_grf_we;  last_waddr = w_grf_addr; last_wdata = w_grf_wdata;
      last_dbe = m_data_byteen; last_ibe = m_int_byteen; last_mwdata = m_data_wdata;

      @(posedge clk);
      if (wr && wa != 5'd0) mr[wa] = res;
      if (be != 4'h0 && !hit)
         for (int i = 0; i < 4; i++)
            if (be[i]) mmem[addr[11:2]][8*i +: 8] = sdata[8*i +: 8];
      if (take) begin mepc = mpc; msr[1] = 1'b1; end
      if (mtc && rd == 5'd12) msr = b & 32'h0000_FC03;
      if (mtc && rd == 5'd14) mepc = b;
      if (eret) msr[1] = 1'b0;
      mpc = npc;
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_ins();
      logic [4:0]  rs, rt, rd, sa;
      logic [15:0] imm;
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sa = 5'($urandom);
      imm = 16'($urandom);
      case ($urandom_range(0, 23))
         0:  return r_ins(rs, rt, rd, 5'd0, 6'h21);
         1:  return r_ins(rs, rt, rd, 5'd0, 6'h23);
         2:  return r_ins(rs, rt, rd, 5'd0, 6'h24);
         3:  return r_ins(rs, rt, rd, 5'd0, 6'h25);
         4:  return r_ins(rs, rt, rd, 5'd0, 6'h2a);
         5:  return r_ins(rs, rt, rd, 5'd0, 6'h2b);
         6:  return r_ins(5'd0, rt, rd, sa, 6'h00);
         7:  return r_ins(rs, rt, rd, 5'd0, 6'h20);
         8:  return r_ins(rs, rt, rd, 5'd0, 6'h22);
         9:  return i_ins(6'h09, rs, rt, imm);
         10: return i_ins(6'h08, rs, rt, imm);
         11: return i_ins(6'h0c, rs, rt, imm);
         12: return i_ins(6'h0d, rs, rt, imm);
         13: return i_ins(6'h0f, 5'd0, rt, imm);
         14: return i_ins(6'h23, rs, rt, imm);
         15: return i_ins(6'h21, rs, rt, imm);
         16: return i_ins(6'h20, rs, rt, imm);
         17: return i_ins(6'h2b, rs, rt, imm);
         18: return i_ins(6'h29, rs, rt, imm);
         19: return i_ins(6'h28, rs, rt, imm);
         20: return {6'h10, 5'd0, rt, 5'(12 + $urandom_range(0, 3)), 11'd0};
         21: return {6'h10, 5'd4, rt, 5'd14, 11'd0};
         22: return i_ins(6'h0e, rs, rt, imm);
         default: return r_ins(rs, rt, rd, 5'd0, 6'h26);
      endcase
   endfunction

   initial begin
      logic [31:0] a;
      reset = 1'b1; interrupt = 1'b0;
      pk_en = 1'b0; pk_idx = 10'd0; pk_val = 32'h0;
      last_we = 1'b0; last_waddr = 5'd0; last_wdata = 32'h0;
      last_dbe = 4'h0; last_ibe = 4'h0; last_mwdata = 32'h0;

      // Program A: stores/loads by lane, jal/jr, bne skip, beq self-loop
      clear_imem();
      a = RESET_PC;
      put(a + 32'h00, i_ins(6'h0d, 5'd0, 5'd1, 16'h1234));
      put(a + 32'h04, i_ins(6'h0f, 5'd0, 5'd2, 16'h8000));
      put(a + 32'h08, i_ins(6'h0d, 5'd2, 5'd2, 16'h00FF));
      put(a + 32'h0C, i_ins(6'h28, 5'd0, 5'd2, 16'h0005));
      put(a + 32'h10, j_ins(6'h03, 32'h0000_3020));
      put(a + 32'h14, i_ins(6'h20, 5'd0, 5'd3, 16'h0005));
      put(a + 32'h18, i_ins(6'h04, 5'd0, 5'd0, 16'hFFFF));
      put(a + 32'h20, i_ins(6'h0f, 5'd0, 5'd4, 16'hABCD));
      put(a + 32'h24, i_ins(6'h0d, 5'd4, 5'd4, 16'h1234));
      put(a + 32'h28, i_ins(6'h29, 5'd0, 5'd4, 16'h0002));
      put(a + 32'h2C, i_ins(6'h21, 5'd0, 5'd5, 16'h0006));
      put(a + 32'h30, i_ins(6'h05, 5'd5, 5'd0, 16'h0001));
      put(a + 32'h34, i_ins(6'h0d, 5'd0, 5'd6, 16'hDEAD));
      put(a + 32'h38, r_ins(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));

      repeat (2) @(posedge clk);
      @(negedge clk);
      do_reset(1'b0);
      for (int i = 0; i < 1024; i++) poke(i, $urandom);
      poke(1, 32'h8001_5555);
      reset = 1'b0;

      step(1'b0);
      chk("ori_waddr", 32'(last_waddr), 32'd1);
      chk("ori_wdata", last_wdata, 32'h0000_1234);
      step(1'b0); step(1'b0); step(1'b0);
      chk("sb_be",    32'(last_dbe), 32'h2);
      chk("sb_wdata", last_mwdata,   32'hFFFF_FFFF);
      step(1'b0);
      chk("jal_link", last_wdata, 32'h0000_3014);
      chk("jal_pc",   macroscopic_pc, 32'h0000_3020);
      step(1'b0); step(1'b0); step(1'b0);
      chk("sh_be",    32'(last_dbe), 32'hC);
      chk("sh_wdata", last_mwdata,   32'h1234_1234);
      step(1'b0);
      chk("lh_sext", last_wdata, 32'hFFFF_8001);
      step(1'b0); step(1'b0);
      chk("jr_pc", macroscopic_pc, 32'h0000_3014);
      step(1'b0);
      chk("lb_sext", last_wdata, 32'hFFFF_FFFF);
      repeat (3) step(1'b0);
      chk("beq_loop", macroscopic_pc, 32'h0000_3018);

      // Program B: interrupt masked by IE, taken at 0x3010, held off by EXL, eret returns
      clear_imem();
      put(a + 32'h00, i_ins(6'h0d, 5'd0, 5'd1, 16'h1001));
      put(a + 32'h04, i_ins(6'h0d, 5'd0, 5'd7, 16'h300C));
      put(a + 32'h08, r_ins(5'd7, 5'd0, 5'd8, 5'd0, 6'h09));
      put(a + 32'h0C, {6'h10, 5'd4, 5'd1, 5'd12, 11'd0});
      put(a + 32'h10, i_ins(6'h0d, 5'd0, 5'd4, 16'h0007));
      put(a + 32'h14, i_ins(6'h04, 5'd0, 5'd0, 16'hFFFF));
      put(HANDLER_PC + 32'h0, i_ins(6'h2b, 5'd0, 5'd1, 16'h7F20));
      put(HANDLER_PC + 32'h4, {6'h10, 5'd0, 5'd6, 5'd14, 11'd0});
      put(HANDLER_PC + 32'h8, 32'h4200_0018);
      do_reset(1'b1);
      reset = 1'b0;
      step(1'b1); step(1'b1); step(1'b1);
      chk("jalr_link", last_wdata, 32'h0000_300C);
      step(1'b1);
      chk("ie0_no_take", macroscopic_pc, 32'h0000_3010);
      step(1'b1);
      chk("int_squash_we", 32'(last_we), 32'h0);
      chk("int_entry_pc",  macroscopic_pc, HANDLER_PC);
      step(1'b1);
      chk("int_store_ibe", 32'(last_ibe), 32'hF);
      chk("int_store_dbe", 32'(last_dbe), 32'h0);
      step(1'b1);
      chk("mfc0_epc", last_wdata, 32'h0000_3010);
      step(1'b0);
      chk("eret_pc", macroscopic_pc, 32'h0000_3010);

      // Reset mid-program with the interrupt pending, then random programs from zeroed GPRs
      clear_imem();
      for (int k = 1; k < 32; k++) put(a + 32'(4 * (k - 1)), r_ins(5'(k), 5'd0, 5'(k), 5'd0, 6'h25));
      for (int k = 1; k < 32; k++) put(a + 32'(4 * (k + 30)), i_ins(6'h0f, 5'd0, 5'(k), 16'($urandom)));
      for (int k = 62; k < 362; k++) put(a + 32'(4 * k), rand_ins());
      do_reset(1'b1);
      reset = 1'b0;
      for (int k = 1; k < 32; k++) begin
         step(1'b0);
         chk("gpr_zero", last_wdata, 32'h0);
      end
      for (int k = 31; k < 362; k++) step(1'($urandom_range(0, 1)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
